service_packet_injector: RTL and testbench

Synthesizable transmitter that builds and sends one Hermes service packet at a time into a PE local port. The packet carries a target address, a size, a service code, the destination task ID and the source task ID, followed by payload flits. It is the generating end of the service traffic (0x10, 0x20, 0x70, …) that the per-PE communication loggers decode: flit 2 is the service code, flit 3 is the destination task ID and flit 4 is the source task ID. It sits between a test or PE-side command source and the router local input, and uses credit-based flow control.

---
 rtl/service_packet_injector.sv | 242 ++++++++++++++++++++++++
 tb/tb_service_packet_injector.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/service_packet_injector.sv
// ---------------------------------------------------------------------------
// service_packet_injector
//
// Purpose:
//   This block builds one Hermes service packet at a time and sends it into a
//   PE local port. The worm layout is:
//     flit 0 : target router address
//     flit 1 : size (payload length + SIZE_OVERHEAD)
//     flit 2 : service code
//     flit 3 : destination task ID
//     flit 4 : source task ID
//     flit 5.. : payload flits, taken from the pl_data/pl_valid stream
//   The router side uses credit-based flow control.
//
// Optional feature (macro INJ_STATS_EN):
//   When the macro is defined, the block counts completed packets
//   (pkt_count) and measures the cycles from start to the last flit
//   (last_cycles). When it is undefined, both outputs are tied to 0 and no
//   counter registers exist.
//
// Ports:
//   rel         in   clock, rising edge
//   reset       in   asynchronous active-low reset
//   start       in   packet request; it is captured only while IDLE
//   target_addr in   flit 0 value
//   service     in   flit 2 value
//   task_dst    in   flit 3 value
//   task_src    in   flit 4 value
//   pl_len      in   number of payload flits (0..MAX_PAYLOAD)
//   pl_data     in   payload flit
//   pl_valid    in   pl_data is valid
//   pl_ready    out  payload flit consumed on this cycle's rising edge
//   tx          out  flit valid toward the router
//   data_out    out  flit toward the router
//   credit_i    in   router can accept a flit this cycle
//   busy        out  packet in progress (HDR through the last accept)
//   done        out  one-cycle pulse after the last flit is accepted
//   pkt_count   out  completed packets (INJ_STATS_EN only, else 0)
//   last_cycles out  start-to-last-flit cycles of the previous packet
//                    (INJ_STATS_EN only, else 0)
//   state_dbg   out  current FSM state encoding, for checkers
//
// Handshakes:
//   Router side : a flit transfers on a rising edge with tx=1 and
//                 credit_i=1. While tx=1 and credit_i=0, tx and data_out stay
//                 stable.
//   Payload side: a payload flit transfers on a rising edge with
//                 pl_valid=1 and pl_ready=1. The source must hold pl_data
//                 stable while pl_valid=1 and pl_ready=0. In PAY, the flit
//                 goes straight through to data_out.
// ---------------------------------------------------------------------------
module service_packet_injector #(
    parameter int FLIT_WIDTH    = 16,
    parameter int MAX_PAYLOAD   = 255,
    parameter int SIZE_OVERHEAD = 3,
    localparam int LEN_W        = $clog2(MAX_PAYLOAD + 1)
) (
    input  logic                  rel,
    input  logic                  reset,
    input  logic                  start,
    input  logic [FLIT_WIDTH-1:0] target_addr,
    input  logic [FLIT_WIDTH-1:0] service,
    input  logic [FLIT_WIDTH-1:0] task_dst,
    input  logic [FLIT_WIDTH-1:0] task_src,
    input  logic [LEN_W-1:0]      pl_len,
    input  logic [FLIT_WIDTH-1:0] pl_data,
    input  logic                  pl_valid,
    output logic                  pl_ready,
    output logic                  tx,
    output logic [FLIT_WIDTH-1:0] data_out,
    input  logic                  credit_i,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           pkt_count,
    output logic [31:0]           last_cycles,
    output logic [2:0]            state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_SIZE = 3'd2,
        S_SERV = 3'd3,
        S_TDST = 3'd4,
        S_TSRC = 3'd5,
        S_PAY  = 3'd6,
        S_DONE = 3'd7
    } state_t;

    state_t                state;
    logic [FLIT_WIDTH-1:0] service_q;
    logic [FLIT_WIDTH-1:0] dst_q;
    logic [FLIT_WIDTH-1:0] src_q;
    logic [FLIT_WIDTH-1:0] data_q;  // header flit currently offered
    logic [LEN_W-1:0]      rem_q;   // payload length, then the down-counter
    logic                  tx_q;    // header flit valid
    logic                  busy_q;
    logic                  done_q;
    logic                  capture;
    logic                  pay_accept;
    logic                  last_accept;

    assign capture    = (state == S_IDLE) && start;
    assign pay_accept = (state == S_PAY) && pl_valid && credit_i;

    // This is the edge that completes the worm. For an empty payload it is the
    // task_src flit; otherwise it is the payload flit accepted while the
    // counter reads 1.
    assign last_accept = ((state == S_TSRC) && credit_i && (rem_q == '0)) ||
                         (pay_accept && (rem_q == LEN_W'(1)));

    // In PAY the payload stream passes straight through. A bubble on
    // pl_valid drops tx but keeps the worm open.
    assign tx        = (state == S_PAY) ? pl_valid : tx_q;
    assign data_out  = (state == S_PAY) ? pl_data  : data_q;
    assign pl_ready  = pay_accept;
    assign busy      = busy_q;
    assign done      = done_q;
    assign state_dbg = state;

    always_ff @(posedge rel or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            service_q <= '0;
            dst_q     <= '0;
            src_q     <= '0;
            data_q    <= '0;
            rem_q     <= '0;
            tx_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        // Every field is latched here, so later input changes
                        // cannot corrupt the worm. The first flit is driven
                        // on the next cycle.
                        service_q <= service;
                        dst_q     <= task_dst;
                        src_q     <= task_src;
                        rem_q     <= pl_len;
                        data_q    <= target_addr;
                        tx_q      <= 1'b1;
                        busy_q    <= 1'b1;
                        state     <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (credit_i) begin
                        data_q <= FLIT_WIDTH'(rem_q) + FLIT_WIDTH'(SIZE_OVERHEAD);
                        state  <= S_SIZE;
                    end
                end
                S_SIZE: begin
                    if (credit_i) begin
                        data_q <= service_q;
                        state  <= S_SERV;
                    end
                end
                S_SERV: begin
                    if (credit_i) begin
                        data_q <= dst_q;
                        state  <= S_TDST;
                    end
                end
                S_TDST: begin
                    if (credit_i) begin
                        data_q <= src_q;
                        state  <= S_TSRC;
                    end
                end
                S_TSRC: begin
                    if (credit_i) begin
                        tx_q   <= 1'b0;
                        data_q <= '0;
                        if (last_accept) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            state  <= S_PAY;
                        end
                    end
                end
                S_PAY: begin
                    if (pay_accept) begin
                        rem_q <= rem_q - LEN_W'(1);
                        if (last_accept) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state  <= S_IDLE;
                    tx_q   <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef INJ_STATS_EN
    logic [31:0] cyc_q;
    logic [31:0] last_q;
    logic [15:0] pkt_q;

    // The capture cycle counts as the first cycle. The counter then advances
    // on every busy edge. The final accept edge is included in the loaded
    // value, so last_cycles spans start through the last flit.
    always_ff @(posedge rel or negedge reset) begin
        if (!reset) begin
            cyc_q  <= '0;
            last_q <= '0;
            pkt_q  <= '0;
        end else begin
            if (capture) begin
                cyc_q <= 32'd1;
            end else if (busy_q) begin
                cyc_q <= cyc_q + 32'd1;
            end
            if (last_accept) begin
                last_q <= cyc_q + 32'd1;
                pkt_q  <= pkt_q + 16'd1;  // wraps 0xFFFF -> 0
            end
        end
    end

    assign pkt_count   = pkt_q;
    assign last_cycles = last_q;
`else
    assign pkt_count   = '0;
    assign last_cycles = '0;
`endif

endmodule

// File: tb/tb_service_packet_injector.sv
// ---------------------------------------------------------------------------
// tb_service_packet_injector
//
// Directed bench for service_packet_injector. It drives hand-built packets
// and records every flit the router accepts (tx & credit_i, sampled on the
// falling edge). It compares that stream against an expected queue and
// checks the cycle timing of flits, done, busy and the statistics outputs.
// ---------------------------------------------------------------------------
module tb_service_packet_injector;

`ifdef INJ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic        rel;
    logic        reset;
    logic        start;
    logic [15:0] target_addr, service, task_dst, task_src;
    logic [7:0]  pl_len;
    logic [15:0] pl_data;
    logic        pl_valid;
    logic        pl_ready;
    logic        tx;
    logic [15:0] data_out;
    logic        credit_i;
    logic        busy;
    logic        done;
    logic [15:0] pkt_count;
    logic [31:0] last_cycles;
    logic [2:0]  state_dbg;

    initial begin
        rel = 1'b0;
        forever #5 rel = ~rel;
    end

    service_packet_injector dut (
        .rel(rel), .reset(reset), .start(start),
        .target_addr(target_addr), .service(service),
        .task_dst(task_dst), .task_src(task_src), .pl_len(pl_len),
        .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
        .tx(tx), .data_out(data_out), .credit_i(credit_i),
        .busy(busy), .done(done), .pkt_count(pkt_count),
        .last_cycles(last_cycles), .state_dbg(state_dbg)
    );

    // ---------------- payload source ----------------
    logic [15:0] pay_mem [0:15];
    int          pay_idx;
    int          pay_n;
    logic        pl_gate;
    logic        take_s;

    assign pl_valid = pl_gate && (pay_idx < pay_n);
    assign pl_data  = pay_mem[pay_idx[3:0]];

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    int          n_acc;
    int          n_ready;
    int          n_checks;
    int          n_fail;

    always @(negedge rel) begin
        take_s = pl_ready;
        if (reset && tx && credit_i) begin
            got_q.push_back(data_out);
            n_acc++;
        end
        if (pl_ready) n_ready++;
    end

    always @(posedge rel) begin
        if (take_s) pay_idx <= pay_idx + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic compare_sb(input string tag);
        int n;
        check_eq({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check_eq({tag, "_flit"}, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge rel);
        #1;
    endtask

    task automatic load_payload(input logic [15:0] a, b, c, input int n);
        pay_mem[0] = a;
        pay_mem[1] = b;
        pay_mem[2] = c;
        pay_idx    = 0;
        pay_n      = n;
    endtask

    task automatic set_fields(input logic [15:0] a, s, d, sr,
                              input logic [7:0] len);
        target_addr = a;
        service     = s;
        task_dst    = d;
        task_src    = sr;
        pl_len      = len;
    endtask

    task automatic scramble();
        set_fields(16'hDEAD, 16'hBEEF, 16'hFACE, 16'hCAFE, 8'd9);
    endtask

    // The caller must be at a cycle boundary with the DUT in IDLE. The task
    // sends one packet with full credit and checks every flit on its own cycle.
    task automatic run_packet(input logic [15:0] a, s, d, sr, input int len);
        logic [15:0] fl[$];
        fl.push_back(a);
        fl.push_back(16'(len + 3));
        fl.push_back(s);
        fl.push_back(d);
        fl.push_back(sr);
        for (int i = 0; i < len; i++) fl.push_back(pay_mem[pay_idx + i]);
        foreach (fl[i]) exp_q.push_back(fl[i]);
        set_fields(a, s, d, sr, 8'(len));
        start    = 1'b1;
        credit_i = 1'b1;
        pl_gate  = 1'b1;
        #1;
        check_eq("capture_no_tx", tx, 1'b0);
        cyc();
        start = 1'b0;
        scramble();
        foreach (fl[i]) begin
            #1;
            check_eq("pkt_tx", tx, 1'b1);
            check_eq("pkt_data", data_out, fl[i]);
            check_eq("pkt_busy", busy, 1'b1);
            check_eq("pkt_pl_ready", pl_ready, (i >= 5));
            cyc();
        end
        #1;
        check_eq("pkt_done", done, 1'b1);
        check_eq("pkt_done_busy", busy, 1'b0);
        check_eq("pkt_done_tx", tx, 1'b0);
        cyc();
        check_eq("pkt_done_pulse", done, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int ready0;
        int acc0;
        n_checks = 0; n_fail = 0; n_acc = 0; n_ready = 0;
        reset = 1'b0; start = 1'b0; credit_i = 1'b0; pl_gate = 1'b0;
        take_s = 1'b0;
        set_fields('0, '0, '0, '0, '0);
        load_payload('0, '0, '0, 0);

        // Reset values
        #23;
        check_eq("rst_tx", tx, 1'b0);
        check_eq("rst_data", data_out, 16'h0);
        check_eq("rst_pl_ready", pl_ready, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_pkt_count", pkt_count, 16'h0);
        check_eq("rst_last_cycles", last_cycles, 32'h0);
        check_eq("rst_state", state_dbg, 3'd0);
        cyc();
        reset = 1'b1;
        cyc();

        // Service 0x0010, two payload flits, full credit
        load_payload(16'hAAAA, 16'hBBBB, 16'h0, 2);
        run_packet(16'h0101, 16'h0010, 16'h0102, 16'h0201, 2);
        compare_sb("svc10");
        check_eq("svc10_last_cycles", last_cycles, STATS ? 32'd8 : 32'd0);
        check_eq("svc10_pkt_count", pkt_count, STATS ? 16'd1 : 16'd0);

        // Service 0x0070, empty payload: the payload source stays valid, but
        // pl_ready must never fire
        load_payload(16'h1234, 16'h0, 16'h0, 1);
        ready0 = n_ready;
        run_packet(16'h0303, 16'h0070, 16'h0A0B, 16'h0C0D, 0);
        compare_sb("svc70");
        check_eq("svc70_no_ready", n_ready - ready0, 0);
        check_eq("svc70_last_cycles", last_cycles, STATS ? 32'd6 : 32'd0);

        // Credit low for 3 cycles while SERV is offered
        load_payload(16'h5555, 16'h0, 16'h0, 1);
        exp_q.push_back(16'h0202); exp_q.push_back(16'h0004);
        exp_q.push_back(16'h0010); exp_q.push_back(16'h0011);
        exp_q.push_back(16'h0022); exp_q.push_back(16'h5555);
        set_fields(16'h0202, 16'h0010, 16'h0011, 16'h0022, 8'd1);
        start = 1'b1; credit_i = 1'b1; pl_gate = 1'b1;
        cyc();
        start = 1'b0;
        scramble();
        for (int j = 0; j < 9; j++) begin
            credit_i = !(j >= 2 && j <= 4);
            #1;
            if (j >= 2 && j <= 5) begin
                check_eq("stall_tx", tx, 1'b1);
                check_eq("stall_data", data_out, 16'h0010);
            end
            cyc();
        end
        #1;
        check_eq("stall_done", done, 1'b1);
        cyc();
        compare_sb("stall");
        check_eq("stall_last_cycles", last_cycles, STATS ? 32'd10 : 32'd0);

        // Payload bubbles: pl_valid low for 2 cycles in PAY
        load_payload(16'h1111, 16'h2222, 16'h3333, 3);
        exp_q.push_back(16'h0404); exp_q.push_back(16'h0006);
        exp_q.push_back(16'h0020); exp_q.push_back(16'h0033);
        exp_q.push_back(16'h0044); exp_q.push_back(16'h1111);
        exp_q.push_back(16'h2222); exp_q.push_back(16'h3333);
        acc0 = n_acc;
        set_fields(16'h0404, 16'h0020, 16'h0033, 16'h0044, 8'd3);
        start = 1'b1; credit_i = 1'b1; pl_gate = 1'b1;
        cyc();
        start = 1'b0;
        scramble();
        for (int j = 0; j < 10; j++) begin
            pl_gate = !(j == 6 || j == 7);
            #1;
            if (j == 5) check_eq("bub_ready", pl_ready, 1'b1);
            if (j == 6 || j == 7) begin
                check_eq("bub_tx", tx, 1'b0);
                check_eq("bub_state", state_dbg, 3'd6);
                check_eq("bub_busy", busy, 1'b1);
            end
            cyc();
        end
        #1;
        check_eq("bub_done", done, 1'b1);
        pl_gate = 1'b1;
        cyc();
        check_eq("bub_acc_total", n_acc - acc0, 8);
        compare_sb("bubble");
        check_eq("bub_last_cycles", last_cycles, STATS ? 32'd11 : 32'd0);
        check_eq("bub_pkt_count", pkt_count, STATS ? 16'd4 : 16'd0);

        // Reset asserted while TDST is offered
        load_payload(16'h7777, 16'h8888, 16'h0, 2);
        exp_q.push_back(16'h0909); exp_q.push_back(16'h0005);
        exp_q.push_back(16'h0040);
        set_fields(16'h0909, 16'h0040, 16'h0099, 16'h00AA, 8'd2);
        start = 1'b1; credit_i = 1'b1;
        cyc();
        start = 1'b0;
        for (int j = 0; j < 3; j++) cyc();
        #1;
        check_eq("abort_pre_state", state_dbg, 3'd4);
        reset = 1'b0;
        #1;
        check_eq("abort_tx", tx, 1'b0);
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_state", state_dbg, 3'd0);
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        compare_sb("abort");
        load_payload(16'h7777, 16'h8888, 16'h0, 2);
        run_packet(16'h0909, 16'h0040, 16'h0099, 16'h00AA, 2);
        compare_sb("post_abort");
        check_eq("abort_pkt_count", pkt_count, STATS ? 16'd1 : 16'd0);

        // Three back-to-back packets with start held high
        do_reset();
        cyc();
        load_payload(16'hC001, 16'hC002, 16'hC003, 3);
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(16'h0505); exp_q.push_back(16'h0004);
            exp_q.push_back(16'h0010); exp_q.push_back(16'h0055);
            exp_q.push_back(16'h0066); exp_q.push_back(16'(16'hC001 + k));
        end
        set_fields(16'h0505, 16'h0010, 16'h0055, 16'h0066, 8'd1);
        credit_i = 1'b1; pl_gate = 1'b1;
        for (int c = 0; c < 28; c++) begin
            start = (c < 24);
            #1;
            check_eq("b2b_done", done, ((c % 8) == 7) && (c < 24));
            if ((c % 8) == 0) check_eq("b2b_idle_busy", busy, 1'b0);
            cyc();
        end
        compare_sb("b2b");
        check_eq("b2b_pkt_count", pkt_count, STATS ? 16'd3 : 16'd0);
        check_eq("b2b_last_cycles", last_cycles, STATS ? 32'd7 : 32'd0);
        check_eq("b2b_end_state", state_dbg, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    // Watchdog: the directed scripts are fixed-length; this only fires if
    // something stalls the simulation itself.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
